// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared func3 codes, state encoding and decode helpers for the divide sequencer
package div_sequencer_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Decode raises start for OP-opcode instructions carrying the M-extension funct7 with func3[2] set
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic is_div_class(input logic [6:0] opcode, input logic [6:0] funct7,
                                          input logic [2:0] f3);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && f3[2];
    endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - radix-2 restoring divide step with the {rem,quo} shift registers
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    // The shifted remainder needs one extra bit; a set top bit always exceeds the divisor
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        rem_nxt = rem_sh[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (init) begin
            rem_q <= '0;
            quo_q <= dividend;
        end else if (step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - DIV/DIVU/REM/REMU sequencer with stall/done; DIV_EARLY_OUT_EN enables |op1|<|op2| early exit
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ITER_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t            state, state_nxt;
    logic [ITER_W-1:0] cnt;
    logic [XLEN-1:0]   divisor_q;
    logic              neg_q_q, neg_r_q, rem_sel_q;

    logic              sgn, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, ovf, early, special;
    logic [XLEN-1:0]   special_res, calc_res;
    logic [XLEN-1:0]   rem_nxt, quo_nxt;
    logic              accept, calc_step, last_step;

    assign sgn  = is_signed_op(func3);
    assign neg1 = sgn & op1[XLEN-1];
    assign neg2 = sgn & op2[XLEN-1];
    assign mag1 = neg1 ? -op1 : op1;
    assign mag2 = neg2 ? -op2 : op2;

    assign div_zero = (op2 == '0);
    assign ovf      = sgn && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early    = !div_zero && (mag1 < mag2);
`else
    assign early    = 1'b0;
`endif
    assign special  = div_zero | ovf | early;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem_op(func3) ? op1 : '1;
        else if (ovf)
            special_res = is_rem_op(func3) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (early)
            special_res = is_rem_op(func3) ? op1 : '0;
    end

    // Fix-up is taken from the final step's combinational output so the result lands on the edge into DONE
    assign calc_res = rem_sel_q ? (neg_r_q ? -rem_nxt : rem_nxt)
                                : (neg_q_q ? -quo_nxt : quo_nxt);

    assign accept    = (state == S_IDLE) && start && !flush;
    assign calc_step = (state == S_CALC) && !flush;
    assign last_step = calc_step && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = special ? S_DONE : S_CALC;
                S_CALC:  if (cnt == '0) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        stall = start & ~done & ~flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            divisor_q <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result    <= '0;
        end else begin
            if (accept) begin
                cnt       <= ITER_W'(XLEN - 1);
                divisor_q <= mag2;
                neg_q_q   <= neg1 ^ neg2;
                neg_r_q   <= neg1;
                rem_sel_q <= is_rem_op(func3);
                if (special)
                    result <= special_res;
            end
            if (calc_step && (cnt != '0))
                cnt <= cnt - 1'b1;
            if (last_step)
                result <= calc_res;
        end
    end

    div_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .init     (accept),
        .step     (calc_step),
        .dividend (mag1),
        .divisor  (divisor_q),
        .rem_nxt  (rem_nxt),
        .quo_nxt  (quo_nxt)
    );

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - randomized and directed bench for div_sequencer against an arithmetic reference model
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func3 = F3_DIVU;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy, stall, done;
    logic [31:0] result;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32), .ITER_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .func3  (func3),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] q, r;
        sgn = (f3 == F3_DIV) || (f3 == F3_REM);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (sgn) begin
            int sa, sb;
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        longint la, lb;
        sgn = (f3 == F3_DIV) || (f3 == F3_REM);
        la = sgn ? longint'(int'(a)) : longint'(a);
        lb = sgn ? longint'(int'(b)) : longint'(b);
        if (la < 0) la = -la;
        if (lb < 0) lb = -lb;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (la < lb) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int stalls;
        int done_cyc;
        @(negedge clk);
        start = 1'b1; flush = 1'b0; func3 = f3; op1 = a; op2 = b;
        #1;
        stalls = stall ? 1 : 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                tests++;
                if (result !== exp_r) begin
                    fails++;
                    $display("FAIL %s result: got %h expected %h", name, result, exp_r);
                end
                tests++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL %s stall_at_done: got %b expected 0", name, stall);
                end
                start = 1'b0;
            end else if (stall) begin
                stalls++;
            end
        end
        tests++;
        if (done_cyc != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, done_cyc, exp_lat);
        end
        tests++;
        if (stalls != exp_lat) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_lat);
        end
        start = 1'b0;
        last_result = exp_r;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, stall} !== 3'b000 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b stall=%b result=%h expected 0 0 0 0",
                     busy, done, stall, result);
        end
        start = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL reset_stall_eq: got %b expected 1", stall);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        last_result = '0;
    endtask

    task automatic test_directed();
        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("div_5_0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", F3_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_3_10", F3_DIVU, 32'd3, 32'd10, 32'd0, ref_latency(F3_DIVU, 32'd3, 32'd10));
        run_op("remu_3_10", F3_REMU, 32'd3, 32'd10, 32'd3, ref_latency(F3_REMU, 32'd3, 32'd10));
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int          kind;
            int          fsel;
            logic [2:0]  f3;
            logic [31:0] a, b;
            kind = $urandom_range(0, 5);
            fsel = $urandom_range(0, 3);
            f3 = 3'b100 | 3'(fsel);
            a = $urandom;
            b = $urandom;
            case (kind)
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: ;
                4: begin a = $urandom_range(0, 1000); b = $urandom_range(1001, 100000); end
                default: begin a = -$urandom_range(1, 100000); b = -$urandom_range(1, 50); end
            endcase
            run_op($sformatf("rand%0d", i), f3, a, b, ref_result(f3, a, b), ref_latency(f3, a, b));
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_0", F3_DIVU, 32'd1000, 32'd9, ref_result(F3_DIVU, 32'd1000, 32'd9), 33);
        run_op("b2b_1", F3_REM, 32'hFFFF_FC18, 32'd7, ref_result(F3_REM, 32'hFFFF_FC18, 32'd7), 33);
        run_op("b2b_2", F3_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_flush();
        bit seen_done;
        @(negedge clk);
        start = 1'b1; func3 = F3_DIVU; op1 = 32'hDEAD_BEEF; op2 = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: got busy=%b expected 0", busy);
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        tests++;
        if (seen_done || result !== last_result) begin
            fails++;
            $display("FAIL flush_no_done: got done_seen=%b result=%h expected 0 %h",
                     seen_done, result, last_result);
        end
        run_op("after_flush_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3, 33);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = F3_DIV; op1 = 32'd50; op2 = 32'd5;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_start_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || result !== last_result) begin
            fails++;
            $display("FAIL flush_start_idle: got busy=%b result=%h expected 0 %h", busy, result, last_result);
        end
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        start = 1'b1; func3 = F3_DIVU; op1 = 32'd12345; op2 = 32'd11;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_calc: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        last_result = '0;
        run_op("after_reset", F3_REMU, 32'd12345, 32'd11, 32'd3, 33);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
